// File: rtl/path_pkg.sv
// path_pkg: shared defaults, invalid-node marker and FSM state type for the path tracer
package path_pkg;
  localparam int NUM_NODES = 26;
  localparam int NODE_W = 5;
  localparam int MAX_LEN = 26;
  localparam int INVALID_NODE = 31;
  typedef enum logic [1:0] {IDLE, TRACE, EMIT} state_t;
endpackage

// File: rtl/path_stack.sv
// path_stack: LIFO of node indices (push/pop/sync clear, top/full/empty/count), async active-low reset
module path_stack import path_pkg::*; #(
  parameter int DEPTH = MAX_LEN,
  parameter int W = NODE_W,
  parameter int CW = $clog2(DEPTH + 1),
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign top = empty ? '0 : mem[AW'(count - 1'b1)];
  always_ff @(posedge clk)
    if (push && !full) mem[AW'(count)] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (push && !full) count <= count + 1'b1;
    else if (pop && !empty) count <= count - 1'b1;
endmodule

// File: rtl/path_trace.sv
// path_trace: walks snapshot prev_node from end_node back to st_node, streams path source-first on out_valid/out_ready with out_last/done/err; PATH_TRACE_HOPCOUNT_EN adds hop_count
module path_trace #(
  parameter int NUM_NODES = path_pkg::NUM_NODES,
  parameter int NODE_W = path_pkg::NODE_W,
  parameter int MAX_LEN = path_pkg::MAX_LEN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NODE_W-1:0]           st_node,
  input  logic [NODE_W-1:0]           end_node,
  input  logic [NUM_NODES*NODE_W-1:0] prev_node,
  input  logic                        out_ready,
`ifdef PATH_TRACE_HOPCOUNT_EN
  output logic [NODE_W-1:0]           hop_count,
`endif
  output logic                        busy,
  output logic                        out_valid,
  output logic [NODE_W-1:0]           out_node,
  output logic                        out_last,
  output logic                        done,
  output logic                        err
);
  import path_pkg::*;
  localparam int CW = $clog2(MAX_LEN + 1);
  state_t state;
  logic [NUM_NODES*NODE_W-1:0] prev_r;
  logic [NODE_W-1:0] st_r, cur, nxt;
  logic [CW-1:0] cnt;
  logic full, empty, hit, fail, bad_start;
  assign nxt = prev_r[int'(cur)*NODE_W +: NODE_W];
  assign hit = cur == st_r;
  assign fail = !hit && (int'(nxt) >= NUM_NODES || cnt == CW'(MAX_LEN - 1));
  assign bad_start = int'(st_node) >= NUM_NODES || int'(end_node) >= NUM_NODES;
  assign busy = state != IDLE;
  assign out_valid = state == EMIT && !empty;
  assign out_last = out_valid && cnt == CW'(1);
  path_stack #(.DEPTH(MAX_LEN), .W(NODE_W), .CW(CW)) u_stack (
    .clk(clk),
    .rst_n(rst_n),
    .clr((state == IDLE && start) || (state == TRACE && fail)),
    .push(state == TRACE && !full),
    .pop(out_valid && out_ready),
    .din(cur),
    .top(out_node),
    .full(full),
    .empty(empty),
    .count(cnt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      prev_r <= '0;
      st_r <= '0;
      cur <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (start) begin
          err <= bad_start;
          state <= bad_start ? IDLE : TRACE;
          prev_r <= prev_node;
          st_r <= st_node;
          cur <= end_node;
        end
        TRACE: if (hit) state <= EMIT;
        else if (fail) begin
          err <= 1'b1;
          state <= IDLE;
        end else cur <= nxt;
        EMIT: if (out_ready && out_last) begin
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef PATH_TRACE_HOPCOUNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hop_count <= '0;
    else if (state == IDLE && start && !bad_start) hop_count <= '0;
    else if (state == TRACE && hit) hop_count <= NODE_W'(cnt);
`endif
endmodule

// File: doc/path_trace.md
PATH_TRACE -- requirements
Module: path_trace

Interface
REQ-001 SHALL have parameter NUM_NODES, 26, number of graph nodes.
REQ-002 SHALL have parameter NODE_W, 5, node index width.
REQ-003 SHALL have parameter MAX_LEN, 26, maximum path length in nodes (stack depth).
REQ-004 SHALL have port clk  in  1  sole clock; all state on posedge.
REQ-005 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle request to trace; sampled in IDLE only.
REQ-007 SHALL have port st_node  in  NODE_W  source node of the search.
REQ-008 SHALL have port end_node  in  NODE_W  destination node of the search.
REQ-009 SHALL have port prev_node  in  NUM_NODES*NODE_W  predecessor table from the search stage; entry n at bits [n*NODE_W +: NODE_W].
REQ-010 SHALL have port busy  out  1  high outside IDLE.
REQ-011 SHALL have port out_valid  out  1  out_node is valid.
REQ-012 SHALL have port out_ready  in  1  consumer accepts out_node.
REQ-013 SHALL have port out_node  out  NODE_W  path node, source first.
REQ-014 SHALL have port out_last  out  1  marks end_node beat.
REQ-015 SHALL have port done  out  1  one-cycle pulse on successful completion.
REQ-016 SHALL have port err  out  1  one-cycle pulse on failed trace.

Function
REQ-017 SHALL implement FSM states IDLE, TRACE, EMIT.
REQ-018 On start in IDLE: SHALL snapshot prev_node, st_node, end_node into internal registers, set cur=end_node, clear stack, go TRACE next cycle.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 If st_node or end_node >= NUM_NODES at start: SHALL pulse err next cycle and stay IDLE.
REQ-021 TRACE: one push per cycle: push cur; if cur==st SHALL go EMIT; else cur <= prev[cur].
REQ-022 TRACE: if prev[cur] >= NUM_NODES, or stack full (MAX_LEN pushes) without reaching st: SHALL pulse err, clear stack, go IDLE.
REQ-023 Path of L nodes SHALL take exactly L cycles in TRACE; out_valid rises the cycle after the final push.
REQ-024 EMIT: out_node = stack top; pop on out_valid & out_ready; out_last high when one entry remains.
REQ-025 out_node/out_last SHALL hold stable while out_valid & !out_ready.
REQ-026 Handshake on the out_last beat SHALL return to IDLE and pulse done in the following cycle.
REQ-027 st_node == end_node SHALL yield a single beat with out_last=1.
REQ-028 Changes on prev_node/st_node/end_node during busy SHALL not affect the trace in progress.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, empty stack, busy=0, out_valid=0, out_node=0, out_last=0, done=0, err=0, regardless of state.
REQ-030 First start SHALL be accepted on the first posedge after rst_n deasserts.

Configuration
REQ-031 Macro PATH_TRACE_HOPCOUNT_EN defined: SHALL add output hop_count (NODE_W bits) = L-1, valid from entry to EMIT until next start, reset 0.
REQ-032 Without PATH_TRACE_HOPCOUNT_EN: no hop_count port or counter logic; all other behaviour identical.

Structure
REQ-033 Shared package path_pkg SHALL hold NUM_NODES, NODE_W, MAX_LEN defaults, INVALID_NODE = 31, and the FSM state typedef.
REQ-034 LIFO SHALL be sub-module path_stack (push, pop, top, full, empty, count, synchronous clear).

Verification
REQ-035 st=0, end=7, prev[7]=3, prev[3]=0, out_ready=1 -> beats 0,3,7, out_last on 7, done one cycle later; hop_count=2 if enabled.
REQ-036 st=end=5 -> single beat 5 with out_last=1, then done.
REQ-037 st=0, end=4, prev[4]=9, prev[9]=4 (cycle) -> err after 26 TRACE cycles, no out_valid.
REQ-038 st=0, end=7, prev[7]=31 -> err after 1 TRACE cycle, returns IDLE.
REQ-039 Path 0,3,7 with out_ready low 3 cycles on first beat -> out_node=0 held stable, then 0,3,7 in order.
REQ-040 rst_n low during EMIT after first beat -> all outputs 0, IDLE; new start traces correctly.
